reqack_monitor_mc: RTL and testbench
====================================

// Module: reqack_monitor_mc
// PURPOSE
//  Synthesisable, parametrised, multi-channel monitor for the req/ack/done/intrpt handshake.
//  Per channel it checks four rules: ack within MAX_ACK cycles of req, done one cycle after ack,
//  no ack coincident with done, and intrpt within INTR_WIN cycles of done.
//  Reports errors as pulses, sticky status and saturating counters.
//  Sits beside the DUT in emulation/silicon builds, where simulation-only assertions are unavailable.
// PARAMETERS
//  NCH       4   number of independent channels
//  MAX_ACK   5   max req->ack delay in cycles (>=1)
//  INTR_WIN  3   max done->intrpt delay in cycles (>=0)
//  CNT_W     16  width of txn_cnt / err_cnt
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  en         in   1       monitor enable; 0 = all channels held IDLE, no checks (disable-iff equivalent)
//  req        in   NCH     per-channel request
//  ack        in   NCH     per-channel acknowledge
//  done       in   NCH     per-channel done
//  intrpt     in   NCH     per-channel interrupt
//  clr_err    in   1       clears err_sticky and err_cnt
//  err_pulse  out  NCH     1-cycle pulse: any rule violated on channel
//  err_sticky out  4*NCH   [4c+0]=ACK_TIMEOUT [4c+1]=DONE_MISS [4c+2]=ACK_DONE [4c+3]=INTR_MISS
//  txn_ok     out  NCH     1-cycle pulse: req..ack..done completed legally
//  txn_cnt    out  CNT_W   total legal transactions, all channels, saturating
//  err_cnt    out  CNT_W   total err_pulse events, all channels, saturating
// BEHAVIOUR
//  Reset: FSMs IDLE, timers 0, all outputs 0. Reset mid-transaction abandons it; no error reported.
//  Timing: inputs sampled at edge N. Verdicts are registered at edge N and visible the cycle after.
//  Per-channel FSM, states IDLE/WAIT_ACK/WAIT_DONE:
//   IDLE:      req=1 -> WAIT_ACK, tmr=1.
//   WAIT_ACK:  ack=1 -> WAIT_DONE.
//              else if tmr==MAX_ACK -> ACK_TIMEOUT, go IDLE.
//              else tmr++.
//              ack at edges T0+1..T0+MAX_ACK is legal (T0 = req edge).
//   WAIT_DONE: done=1 -> txn_ok pulse, IDLE.
//              else -> DONE_MISS, IDLE.
//  Req while not IDLE is ignored (non-overlapping). Req in the same cycle as the return to IDLE is also ignored.
//  Ack in the same cycle as req in IDLE does not count (min delay 1).
//  ACK_DONE: ack&done sampled together, in any state, independent of the FSM.
//   In WAIT_DONE this flags ACK_DONE and still completes with txn_ok.
//  Interrupt window, independent of the FSM:
//   done=1 with no window pending: intrpt=1 same edge -> satisfied.
//    Else open window with itmr=INTR_WIN; itmr decrements each edge.
//   intrpt=1 while pending -> close.
//   itmr==0 with no intrpt -> INTR_MISS, close.
//   INTR_WIN=0 means intrpt is required at the done edge itself.
//   Further done while pending does not restart the window.
//  en=0: FSMs forced IDLE, windows closed, no new errors. Sticky bits and counters hold.
//  err_pulse[c] = OR of the 4 rule flags of channel c for that cycle. Several bits may set together.
//  err_sticky: set by rule flags, cleared by clr_err. Set wins over clr_err in the same cycle.
//  txn_cnt += popcount(txn_ok); err_cnt += popcount(err_pulse).
//   Both clamp at 2^CNT_W-1 with no wrap; the add is computed CNT_W+$clog2(NCH)+1 wide, then clamped.
//  clr_err zeroes err_cnt (new pulses that cycle are counted after clear). txn_cnt is cleared only by reset.
//  Channels are fully independent; no cross-channel interaction except the shared counters.
// TESTING
//  1 ch0: req@0, ack@3, done@4, intrpt@6 -> txn_ok[0] pulse; txn_cnt=1; no errors.
//  2 ch1: req@0, no ack -> ACK_TIMEOUT at edge 5 (MAX_ACK=5); err_pulse[1]; err_sticky[4]=1; err_cnt=1.
//  3 ch2: req@0, ack@1, done absent @2 -> DONE_MISS. Separately ack&done@10 -> ACK_DONE.
//    Separately done@20 with no intrpt to edge 23 -> INTR_MISS at 23; intrpt@23 -> no error.
//  4 All 4 channels time out on the same edge -> err_cnt+=4.
//    Preload near max (CNT_W=3): counter saturates at 7.
//    clr_err with a simultaneous new error -> sticky bit remains 1.
//  5 reset@2 mid WAIT_ACK -> all outputs 0, no error. en=0 during a req..timeout span -> no error.
//    Req ignored while busy; back-to-back req at the completion edge is not accepted.

Source files
------------

// File: rtl/reqack_monitor_mc.sv
// Per-channel req/ack/done/intrpt protocol checker with sticky status and saturating counters.
// Verdicts registered on the sampling edge, visible next cycle; purely observational, no backpressure.
module reqack_monitor_mc #(
    parameter int NCH      = 4,
    parameter int MAX_ACK  = 5,
    parameter int INTR_WIN = 3,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [NCH-1:0]     req,
    input  logic [NCH-1:0]     ack,
    input  logic [NCH-1:0]     done,
    input  logic [NCH-1:0]     intrpt,
    input  logic               clr_err,
    output logic [NCH-1:0]     err_pulse,
    output logic [4*NCH-1:0]   err_sticky,
    output logic [NCH-1:0]     txn_ok,
    output logic [CNT_W-1:0]   txn_cnt,
    output logic [CNT_W-1:0]   err_cnt
);
    localparam int TW = $clog2(MAX_ACK + 1);
    localparam int IW = (INTR_WIN < 2) ? 1 : $clog2(INTR_WIN);
    localparam int SW = CNT_W + $clog2(NCH) + 1;

    localparam logic [TW-1:0] TMR_MAX   = TW'(MAX_ACK);
    localparam logic [IW-1:0] ITMR_LOAD = IW'((INTR_WIN > 0) ? INTR_WIN - 1 : 0);
    localparam logic [SW-1:0] CNT_MAX   = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_ACK  = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    logic [1:0]       state     [NCH];
    logic [1:0]       state_nxt [NCH];
    logic [TW-1:0]    tmr       [NCH];
    logic [TW-1:0]    tmr_nxt   [NCH];
    logic             ipend     [NCH];
    logic             ipend_nxt [NCH];
    logic [IW-1:0]    itmr      [NCH];
    logic [IW-1:0]    itmr_nxt  [NCH];

    logic [4*NCH-1:0] flags;
    logic [NCH-1:0]   err_nxt;
    logic [NCH-1:0]   ok_nxt;
    logic [SW-1:0]    tsum;
    logic [SW-1:0]    esum;

    always_comb begin
        flags   = '0;
        ok_nxt  = '0;
        for (int c = 0; c < NCH; c++) begin
            state_nxt[c] = state[c];
            tmr_nxt[c]   = tmr[c];
            ipend_nxt[c] = ipend[c];
            itmr_nxt[c]  = itmr[c];
            if (!en) begin
                state_nxt[c] = IDLE;
                tmr_nxt[c]   = '0;
                ipend_nxt[c] = 1'b0;
                itmr_nxt[c]  = '0;
            end else begin
                case (state[c])
                    IDLE: begin
                        if (req[c]) begin
                            state_nxt[c] = WAIT_ACK;
                            tmr_nxt[c]   = TW'(1);
                        end
                    end
                    WAIT_ACK: begin
                        if (ack[c]) begin
                            state_nxt[c] = WAIT_DONE;
                        end else if (tmr[c] == TMR_MAX) begin
                            flags[4*c+0] = 1'b1;
                            state_nxt[c] = IDLE;
                            tmr_nxt[c]   = '0;
                        end else begin
                            tmr_nxt[c] = tmr[c] + TW'(1);
                        end
                    end
                    WAIT_DONE: begin
                        if (done[c]) ok_nxt[c] = 1'b1;
                        else         flags[4*c+1] = 1'b1;
                        state_nxt[c] = IDLE;
                        tmr_nxt[c]   = '0;
                    end
                    default: begin
                        state_nxt[c] = IDLE;
                        tmr_nxt[c]   = '0;
                    end
                endcase

                flags[4*c+2] = ack[c] & done[c];

                // The window is not re-armed by a done that arrives while one is already open
                if (ipend[c]) begin
                    if (intrpt[c]) begin
                        ipend_nxt[c] = 1'b0;
                    end else if (itmr[c] == '0) begin
                        flags[4*c+3] = 1'b1;
                        ipend_nxt[c] = 1'b0;
                    end else begin
                        itmr_nxt[c] = itmr[c] - IW'(1);
                    end
                end else if (done[c] && !intrpt[c]) begin
                    if (INTR_WIN == 0) begin
                        flags[4*c+3] = 1'b1;
                    end else begin
                        ipend_nxt[c] = 1'b1;
                        itmr_nxt[c]  = ITMR_LOAD;
                    end
                end
            end
        end

        for (int c = 0; c < NCH; c++) begin
            err_nxt[c] = |flags[4*c +: 4];
        end

        // Sums are formed wide enough for every channel firing at once, then clamped
        tsum = {{(SW-CNT_W){1'b0}}, txn_cnt};
        esum = clr_err ? '0 : {{(SW-CNT_W){1'b0}}, err_cnt};
        for (int c = 0; c < NCH; c++) begin
            tsum = tsum + SW'(ok_nxt[c]);
            esum = esum + SW'(err_nxt[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                state[c] <= IDLE;
                tmr[c]   <= '0;
                ipend[c] <= 1'b0;
                itmr[c]  <= '0;
            end
            err_pulse  <= '0;
            err_sticky <= '0;
            txn_ok     <= '0;
            txn_cnt    <= '0;
            err_cnt    <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                state[c] <= state_nxt[c];
                tmr[c]   <= tmr_nxt[c];
                ipend[c] <= ipend_nxt[c];
                itmr[c]  <= itmr_nxt[c];
            end
            err_pulse  <= err_nxt;
            err_sticky <= (clr_err ? '0 : err_sticky) | flags;
            txn_ok     <= ok_nxt;
            txn_cnt    <= (tsum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : tsum[CNT_W-1:0];
            err_cnt    <= (esum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : esum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_reqack_monitor_mc.sv
// Directed bench for reqack_monitor_mc: expected output events are queued as stimulus is issued
// and a negedge monitor pops and compares whenever either instance presents a pulse.
module tb_reqack_monitor_mc;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        clr_err;
    logic [3:0]  req, ack, done, intrpt;

    logic [3:0]  err_pulse, txn_ok;
    logic [15:0] err_sticky, txn_cnt, err_cnt;
    logic [3:0]  s_err_pulse, s_txn_ok;
    logic [15:0] s_err_sticky;
    logic [2:0]  s_txn_cnt, s_err_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  ep;
        logic [3:0]  tok;
        logic [15:0] sticky;
        int          txn;
        int          err;
        int          stxn;
        int          serr;
    } exp_t;

    exp_t expq[$];

    int          m_txn, m_err, m_stxn, m_serr;
    logic [15:0] m_sticky;

    always #5 clk = ~clk;

    reqack_monitor_mc u_dut (
        .clk(clk), .reset(reset), .en(en),
        .req(req), .ack(ack), .done(done), .intrpt(intrpt), .clr_err(clr_err),
        .err_pulse(err_pulse), .err_sticky(err_sticky), .txn_ok(txn_ok),
        .txn_cnt(txn_cnt), .err_cnt(err_cnt)
    );

    reqack_monitor_mc #(.CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .en(en),
        .req(req), .ack(ack), .done(done), .intrpt(intrpt), .clr_err(clr_err),
        .err_pulse(s_err_pulse), .err_sticky(s_err_sticky), .txn_ok(s_txn_ok),
        .txn_cnt(s_txn_cnt), .err_cnt(s_err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Records one expected pulse cycle; clr marks that clr_err is asserted on that same edge
    task automatic expect_ev(input logic [3:0] ep, input logic [3:0] tok,
                             input logic [15:0] set, input bit clr);
        exp_t e;
        if (clr) begin
            m_sticky = '0;
            m_err    = 0;
            m_serr   = 0;
        end
        m_sticky = m_sticky | set;
        m_txn    = m_txn + $countones(tok);
        m_err    = m_err + $countones(ep);
        m_stxn   = (m_stxn + $countones(tok) > 7) ? 7 : m_stxn + $countones(tok);
        m_serr   = (m_serr + $countones(ep) > 7) ? 7 : m_serr + $countones(ep);
        e.ep = ep; e.tok = tok; e.sticky = m_sticky;
        e.txn = m_txn; e.err = m_err; e.stxn = m_stxn; e.serr = m_serr;
        expq.push_back(e);
    endtask

    task automatic model_reset();
        m_txn = 0; m_err = 0; m_stxn = 0; m_serr = 0; m_sticky = '0;
    endtask

    task automatic cyc(input logic [3:0] r, input logic [3:0] a,
                       input logic [3:0] d, input logic [3:0] i);
        req = r; ack = a; done = d; intrpt = i;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(4'h0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_err_pulse"}, 32'(err_pulse), 0);
        chk({tag, "_err_sticky"}, 32'(err_sticky), 0);
        chk({tag, "_txn_ok"}, 32'(txn_ok), 0);
        chk({tag, "_txn_cnt"}, 32'(txn_cnt), 0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
        chk({tag, "_sat_err_cnt"}, 32'(s_err_cnt), 0);
    endtask

    // Monitor: every pulse on either instance must match the next queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && ((err_pulse | txn_ok | s_err_pulse | s_txn_ok) != 4'h0)) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: err_pulse=%b txn_ok=%b with nothing expected at %0t",
                             err_pulse, txn_ok, $time);
                end else begin
                    e = expq.pop_front();
                    chk("err_pulse", 32'(err_pulse), 32'(e.ep));
                    chk("txn_ok", 32'(txn_ok), 32'(e.tok));
                    chk("err_sticky", 32'(err_sticky), 32'(e.sticky));
                    chk("txn_cnt", 32'(txn_cnt), 32'(e.txn));
                    chk("err_cnt", 32'(err_cnt), 32'(e.err));
                    chk("sat_err_pulse", 32'(s_err_pulse), 32'(e.ep));
                    chk("sat_txn_ok", 32'(s_txn_ok), 32'(e.tok));
                    chk("sat_txn_cnt", 32'(s_txn_cnt), 32'(e.stxn));
                    chk("sat_err_cnt", 32'(s_err_cnt), 32'(e.serr));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b1; clr_err = 1'b0;
        req = '0; ack = '0; done = '0; intrpt = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        idle(2);

        // ch0 legal transaction, intrpt two edges after done
        cyc(4'h1, 4'h0, 4'h0, 4'h0);
        idle(2);
        cyc(4'h0, 4'h1, 4'h0, 4'h0);
        expect_ev(4'h0, 4'h1, 16'h0000, 1'b0);
        cyc(4'h0, 4'h0, 4'h1, 4'h0);
        idle(1);
        cyc(4'h0, 4'h0, 4'h0, 4'h1);
        idle(2);

        // ch1 ack timeout on the fifth edge after req
        cyc(4'h2, 4'h0, 4'h0, 4'h0);
        idle(4);
        expect_ev(4'h2, 4'h0, 16'h0010, 1'b0);
        idle(1);
        idle(2);

        // ch2 done missing one edge after ack
        cyc(4'h4, 4'h0, 4'h0, 4'h0);
        cyc(4'h0, 4'h4, 4'h0, 4'h0);
        expect_ev(4'h4, 4'h0, 16'h0200, 1'b0);
        idle(1);
        idle(2);

        // ch2 ack and done together while idle; intrpt same edge closes the window
        expect_ev(4'h4, 4'h0, 16'h0400, 1'b0);
        cyc(4'h0, 4'h4, 4'h4, 4'h4);
        idle(2);

        // ch2 done with no intrpt for three edges
        cyc(4'h0, 4'h0, 4'h4, 4'h0);
        idle(2);
        expect_ev(4'h4, 4'h0, 16'h0800, 1'b0);
        idle(1);
        idle(2);

        // ch2 intrpt on the last legal edge of the window
        cyc(4'h0, 4'h0, 4'h4, 4'h0);
        idle(2);
        cyc(4'h0, 4'h0, 4'h0, 4'h4);
        idle(3);

        // All channels time out together; the 3-bit error counter clamps at 7
        cyc(4'hF, 4'h0, 4'h0, 4'h0);
        idle(4);
        expect_ev(4'hF, 4'h0, 16'h1111, 1'b0);
        idle(1);
        idle(2);

        // clr_err on the same edge as a new ch3 timeout
        cyc(4'h8, 4'h0, 4'h0, 4'h0);
        idle(4);
        expect_ev(4'h8, 4'h0, 16'h1000, 1'b1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        idle(2);

        // Ack coincident with req does not count
        cyc(4'h1, 4'h1, 4'h0, 4'h0);
        idle(4);
        expect_ev(4'h1, 4'h0, 16'h0001, 1'b0);
        idle(1);
        idle(2);

        // Ack exactly MAX_ACK edges after req is still legal
        cyc(4'h2, 4'h0, 4'h0, 4'h0);
        idle(4);
        cyc(4'h0, 4'h2, 4'h0, 4'h0);
        expect_ev(4'h0, 4'h2, 16'h0000, 1'b0);
        cyc(4'h0, 4'h0, 4'h2, 4'h2);
        idle(2);

        // Req while busy and req on the completion edge are both ignored
        cyc(4'h1, 4'h0, 4'h0, 4'h0);
        cyc(4'h1, 4'h0, 4'h0, 4'h0);
        cyc(4'h0, 4'h1, 4'h0, 4'h0);
        expect_ev(4'h0, 4'h1, 16'h0000, 1'b0);
        cyc(4'h1, 4'h0, 4'h1, 4'h1);
        idle(7);

        // Reset in the middle of WAIT_ACK abandons the transaction silently
        cyc(4'h1, 4'h0, 4'h0, 4'h0);
        idle(1);
        reset = 1'b1;
        idle(1);
        chk_all_zero("midreset");
        model_reset();
        reset = 1'b0;
        idle(7);

        // Disabled monitor across a full timeout span
        cyc(4'h2, 4'h0, 4'h0, 4'h0);
        en = 1'b0;
        idle(6);
        en = 1'b1;
        idle(3);

        // Counters restart from zero after reset
        cyc(4'h4, 4'h0, 4'h0, 4'h0);
        cyc(4'h0, 4'h4, 4'h0, 4'h0);
        expect_ev(4'h0, 4'h4, 16'h0000, 1'b0);
        cyc(4'h0, 4'h0, 4'h4, 4'h4);
        idle(3);

        chk("queue_drained", 32'(expq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
